// File: rtl/rf_arb_pkg.sv
// Shared constants, write-port control payload and round-robin helper for the
// register-file write-back arbiter.
package rf_arb_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Registered write-port control toward the register file
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] dest;
  } wb_ctrl_t;

  // Pointer moves to the requester after the one just granted
  function automatic int unsigned rr_next_ptr(input int unsigned idx,
                                              input int unsigned num);
    int unsigned nxt;
    nxt = idx + 32'd1;
    if (nxt >= num) nxt = 32'd0;
    return nxt;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back requester bus, register-file write port and decode scoreboard
// signals of rf_wb_arbiter; master = execution/decode side, slave = arbiter.
interface rf_wb_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 3
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_dest;
  logic [NUM_REQ*WIDTH-1:0]      req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          write_enable;
  logic [REG_ADDR_W-1:0]         Destination_select;
  logic [WIDTH-1:0]              DATA;

  logic                          reserve_valid;
  logic [REG_ADDR_W-1:0]         reserve_dest;
  logic [REG_ADDR_W-1:0]         Source_select_0;
  logic [REG_ADDR_W-1:0]         Source_select_1;
  logic                          hazard_0;
  logic                          hazard_1;
  logic [REG_COUNT-1:0]          busy;

  modport master (
    output req_valid, req_dest, req_data,
    output reserve_valid, reserve_dest, Source_select_0, Source_select_1,
    input  req_ready, write_enable, Destination_select, DATA,
    input  hazard_0, hazard_1, busy
  );

  modport slave (
    input  req_valid, req_dest, req_data,
    input  reserve_valid, reserve_dest, Source_select_0, Source_select_1,
    output req_ready, write_enable, Destination_select, DATA,
    output hazard_0, hazard_1, busy
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin grant logic: one-hot grant searched from the pointer upward,
// plus the pointer value to load when the grant is accepted.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic [PTR_W-1:0]   ptr_next
);

  logic        found;
  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && valid[PTR_W'(cand)]) begin
        found                = 1'b1;
        grant[PTR_W'(cand)]  = 1'b1;
        grant_idx            = PTR_W'(cand);
      end
    end
    ptr_next = (accept && found) ? PTR_W'(rr_next_ptr(32'(grant_idx), NUM_REQ)) : ptr;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant, registered write port
// and a busy scoreboard for RAW hazards (built when RF_WB_SCOREBOARD_EN is defined).
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  rf_wb_arbiter_if.slave       bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_dest;
  logic [WIDTH-1:0]      sel_data;
  wb_ctrl_t              ctrl_q;
  logic [WIDTH-1:0]      data_q;

  // A grant taken during flush is still handshaken but never written
  assign accept = (|grant) & ~flush;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .valid     (bus.req_valid),
    .ptr       (ptr_q),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr_next  (ptr_d)
  );

  assign bus.req_ready = grant;
  assign sel_dest      = bus.req_dest[32'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data      = bus.req_data[32'(grant_idx)*WIDTH +: WIDTH];

  // Output stage: writes to x0 load the payload but never strobe the port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        ctrl_q.we   <= (sel_dest != ZERO_REG);
        ctrl_q.dest <= sel_dest;
        data_q      <= sel_data;
      end else begin
        ctrl_q.we   <= 1'b0;
      end
    end
  end

  assign bus.write_enable       = ctrl_q.we;
  assign bus.Destination_select = ctrl_q.dest;
  assign bus.DATA               = data_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  // Set after clear so a fresh reservation survives a same-cycle retire
  always_comb begin
    busy_d = busy_q;
    if (ctrl_q.we) busy_d[ctrl_q.dest] = 1'b0;
    if (bus.reserve_valid && (bus.reserve_dest != ZERO_REG))
      busy_d[bus.reserve_dest] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign bus.busy     = busy_q;
  assign bus.hazard_0 = (bus.Source_select_0 != ZERO_REG) & busy_q[bus.Source_select_0];
  assign bus.hazard_1 = (bus.Source_select_1 != ZERO_REG) & busy_q[bus.Source_select_1];
`else
  logic unused_sb;
  assign unused_sb    = ^{bus.reserve_valid, bus.reserve_dest,
                          bus.Source_select_0, bus.Source_select_1};
  assign bus.busy     = '0;
  assign bus.hazard_0 = 1'b0;
  assign bus.hazard_1 = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a behavioural model pushes expected
// write-port/busy values per cycle and the DUT outputs are popped and compared.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 3;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  rf_wb_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic [31:0] m_busy;

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_dest = 5'd0;
    m_data = 32'd0;
    m_busy = 32'd0;
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] d, input logic [31:0] x);
    bus.req_valid[i]         = v;
    bus.req_dest[i*5 +: 5]   = d;
    bus.req_data[i*32 +: 32] = x;
  endtask

  task automatic clear_inputs();
    bus.req_valid       = '0;
    bus.req_dest        = '0;
    bus.req_data        = '0;
    bus.reserve_valid   = 1'b0;
    bus.reserve_dest    = 5'd0;
    bus.Source_select_0 = 5'd0;
    bus.Source_select_1 = 5'd0;
    flush               = 1'b0;
  endtask

  // One clock: check grant, advance model, push expectation, pop after the edge
  task automatic step();
    int                 g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [31:0]        nb;
    exp_t               e;
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (m_ptr + k) % NUM_REQ;
      if (g < 0 && bus.req_valid[c]) g = c;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checks++;
    if (bus.req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
    end
    nb = m_busy;
    if (m_we) nb[m_dest] = 1'b0;
    if (bus.reserve_valid && bus.reserve_dest != 5'd0) nb[bus.reserve_dest] = 1'b1;
    if (flush) nb = 32'd0;
    if (g >= 0 && !flush) begin
      m_dest = bus.req_dest[g*5 +: 5];
      m_data = bus.req_data[g*32 +: 32];
      m_we   = (m_dest != 5'd0);
      m_ptr  = (g + 1) % NUM_REQ;
    end else begin
      m_we   = 1'b0;
    end
    m_busy = nb;
    e.we   = m_we;
    e.dest = m_dest;
    e.data = m_data;
    e.busy = SB_EN ? m_busy : 32'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks += 4;
    if (bus.write_enable !== e.we) begin
      errors++;
      $display("FAIL write_enable: got %b expected %b", bus.write_enable, e.we);
    end
    if (bus.Destination_select !== e.dest) begin
      errors++;
      $display("FAIL Destination_select: got %0d expected %0d", bus.Destination_select, e.dest);
    end
    if (bus.DATA !== e.data) begin
      errors++;
      $display("FAIL DATA: got %h expected %h", bus.DATA, e.data);
    end
    if (bus.busy !== e.busy) begin
      errors++;
      $display("FAIL busy: got %h expected %h", bus.busy, e.busy);
    end
    @(negedge clk);
  endtask

  task automatic check_hazards(input logic [4:0] s0, input logic [4:0] s1);
    logic e0, e1;
    bus.Source_select_0 = s0;
    bus.Source_select_1 = s1;
    #1;
    e0 = SB_EN && (s0 != 5'd0) && m_busy[s0];
    e1 = SB_EN && (s1 != 5'd0) && m_busy[s1];
    checks += 2;
    if (bus.hazard_0 !== e0) begin
      errors++;
      $display("FAIL hazard_0 src=%0d: got %b expected %b", s0, bus.hazard_0, e0);
    end
    if (bus.hazard_1 !== e1) begin
      errors++;
      $display("FAIL hazard_1 src=%0d: got %b expected %b", s1, bus.hazard_1, e1);
    end
  endtask

  task automatic check_all_zero(input string tag, input logic [NUM_REQ-1:0] exp_ready);
    checks += 5;
    if (bus.write_enable !== 1'b0) begin
      errors++; $display("FAIL %s write_enable: got %b expected 0", tag, bus.write_enable);
    end
    if (bus.Destination_select !== 5'd0) begin
      errors++; $display("FAIL %s Destination_select: got %0d expected 0", tag, bus.Destination_select);
    end
    if (bus.DATA !== 32'd0) begin
      errors++; $display("FAIL %s DATA: got %h expected 0", tag, bus.DATA);
    end
    if (bus.busy !== 32'd0) begin
      errors++; $display("FAIL %s busy: got %h expected 0", tag, bus.busy);
    end
    if (bus.req_ready !== exp_ready) begin
      errors++; $display("FAIL %s req_ready: got %b expected %b", tag, bus.req_ready, exp_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset", 3'b000);
    check_hazards(5'd7, 5'd11);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_grant();
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready: got %b expected 010", bus.req_ready);
    end
    step();
    set_req(1, 1'b0, 5'd0, 32'd0);
    checks += 3;
    if (bus.write_enable !== 1'b1 || bus.Destination_select !== 5'd5 || bus.DATA !== 32'hDEADBEEF) begin
      errors += 3;
      $display("FAIL single_write: got we=%b dest=%0d data=%h expected 1/5/deadbeef",
               bus.write_enable, bus.Destination_select, bus.DATA);
    end
    step();
  endtask

  task automatic test_round_robin();
    int order [6];
    order = '{0, 1, 2, 0, 1, 2};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      logic [NUM_REQ-1:0] oh;
      #1;
      oh = '0;
      oh[order[c]] = 1'b1;
      checks++;
      if (bus.req_ready !== oh) begin
        errors++; $display("FAIL rr_order cycle %0d: got %b expected %b", c, bus.req_ready, oh);
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_x0_discard();
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_scoreboard();
    bus.reserve_valid = 1'b1;
    bus.reserve_dest  = 5'd7;
    check_hazards(5'd7, 5'd0);
    step();
    bus.reserve_valid = 1'b0;
    check_hazards(5'd7, 5'd7);
    check_hazards(5'd0, 5'd6);
    set_req(2, 1'b1, 5'd7, 32'h0000_0077);
    step();
    set_req(2, 1'b0, 5'd0, 32'd0);
    step();
    check_hazards(5'd7, 5'd7);
    bus.reserve_valid = 1'b1;
    bus.reserve_dest  = 5'd7;
    step();
    bus.reserve_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h0000_0070);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    bus.reserve_valid = 1'b1;
    bus.reserve_dest  = 5'd7;
    step();
    bus.reserve_valid = 1'b0;
    checks++;
    if (bus.busy[7] !== SB_EN) begin
      errors++; $display("FAIL set_wins busy7: got %b expected %b", bus.busy[7], SB_EN);
    end
    check_hazards(5'd0, 5'd7);
  endtask

  task automatic test_flush();
    bus.reserve_valid = 1'b1;
    bus.reserve_dest  = 5'd11;
    step();
    bus.reserve_valid = 1'b0;
    checks++;
    if (bus.busy !== (SB_EN ? 32'h0000_0880 : 32'h0)) begin
      errors++; $display("FAIL pre_flush busy: got %h expected %h", bus.busy, SB_EN ? 32'h880 : 32'h0);
    end
    flush = 1'b1;
    set_req(1, 1'b1, 5'd3, 32'hF1F1_F1F1);
    step();
    flush = 1'b0;
    set_req(1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 20), 32'hB000_0000 + 32'(i));
    step();
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 4), 32'hC000_0000 + 32'(i));
    bus.reserve_valid = 1'b1;
    bus.reserve_dest  = 5'd9;
    step();
    bus.reserve_valid = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset", 3'b001);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_x0_discard();
    test_scoreboard();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
